// File: rtl/matrix_multiplier_gf8.sv
// Streaming GF(2^8) inner product (AES field, poly 0x11B): four (A,B) pairs per group, XOR-sum on result.
// Optional macro GF8_PRODUCT_PIPE_EN registers the product and last-element flag, adding one cycle of latency.
module matrix_multiplier_gf8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] result
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] r;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return r;
  endfunction

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic [7:0] acc_q;
  logic [7:0] acc_d;
  logic [7:0] result_q;
  logic [7:0] result_d;
  logic [7:0] prod;
  logic [7:0] acc_in;
  logic       acc_first;
  logic       acc_last;

  assign prod  = gf_mul(A, B);
  assign cnt_d = cnt_q + 2'd1;

`ifdef GF8_PRODUCT_PIPE_EN
  logic [7:0] prod_q;
  logic       last_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prod_q <= 8'h00;
      last_q <= 1'b0;
    end else begin
      prod_q <= prod;
      last_q <= (cnt_q == 2'd3);
    end
  end

  // acc is already zero whenever a group begins (after reset or a last element)
  assign acc_in    = prod_q;
  assign acc_first = 1'b0;
  assign acc_last  = last_q;
`else
  assign acc_in    = prod;
  assign acc_first = (cnt_q == 2'd0);
  assign acc_last  = (cnt_q == 2'd3);
`endif

  always_comb begin
    acc_d    = acc_q ^ acc_in;
    result_d = result_q;
    if (acc_first) begin
      acc_d = acc_in;
    end
    if (acc_last) begin
      result_d = acc_q ^ acc_in;
      acc_d    = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= 2'd0;
      acc_q    <= 8'h00;
      result_q <= 8'h00;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_matrix_multiplier_gf8.sv
// Bench for matrix_multiplier_gf8: vector table, reset/restart sequences, random stream vs reference model.
module tb_matrix_multiplier_gf8;

`ifdef GF8_PRODUCT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] result;

  matrix_multiplier_gf8 dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [7:0]      exp;
    string           nm;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] exp;
    string      nm;
  } due_t;

  int         n_chk;
  int         n_fail;
  int         cyc_n;
  logic [7:0] grp[$];
  logic [7:0] ideal;
  logic [7:0] ideal_prev;
  due_t       dq[$];
  vec_t       vt[6];

  // Polynomial product then long division by x^8+x^4+x^3+x+1
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): result=%02h expected=%02h", nm, cyc_n, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns after posedge, update model and compare.
  task automatic cyc(input logic [7:0] a, input logic [7:0] b, input logic r, input string nm);
    logic [7:0] vis;
    @(negedge clk);
    A     = a;
    B     = b;
    reset = r;
    @(posedge clk);
    #1;
    cyc_n++;
    ideal_prev = ideal;
    if (!r) begin
      grp.delete();
      ideal = 8'h00;
    end else begin
      grp.push_back(ref_mul(a, b));
      if (grp.size() == 4) begin
        ideal = grp[0] ^ grp[1] ^ grp[2] ^ grp[3];
        grp.delete();
      end
    end
`ifdef GF8_PRODUCT_PIPE_EN
    vis = r ? ideal_prev : 8'h00;
`else
    vis = ideal;
`endif
    chk({nm, "_model"}, result, vis);
    if (dq.size() > 0 && dq[0].due == cyc_n) begin
      chk(dq[0].nm, result, dq[0].exp);
      void'(dq.pop_front());
    end
  endtask

  task automatic run_vec(input vec_t v);
    due_t d;
    d.due = cyc_n + 3 + LAT;
    d.exp = v.exp;
    d.nm  = v.nm;
    dq.push_back(d);
    for (int k = 0; k < 4; k++) cyc(v.a[k], v.b[k], 1'b1, v.nm);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc_n = 0;
    ideal = 8'h00;
    ideal_prev = 8'h00;
    reset = 1'b0;
    A = 8'h00;
    B = 8'h00;

    vt[0].a = {8'h04, 8'h03, 8'h02, 8'h01}; vt[0].b = {8'h08, 8'h07, 8'h06, 8'h05};
    vt[0].exp = 8'h20; vt[0].nm = "basic";
    vt[1].a = {8'h01, 8'h01, 8'h03, 8'h02}; vt[1].b = {8'hA6, 8'h46, 8'h6E, 8'h87};
    vt[1].exp = 8'h47; vt[1].nm = "mixcol";
    vt[2].a = {8'h09, 8'h0D, 8'h0B, 8'h0E}; vt[2].b = {8'hED, 8'h94, 8'h37, 8'h47};
    vt[2].exp = 8'h87; vt[2].nm = "invmixcol";
    vt[3].a = {8'h00, 8'h00, 8'h00, 8'h00}; vt[3].b = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vt[3].exp = 8'h00; vt[3].nm = "zero_coef";
    vt[4].a = {8'h01, 8'h01, 8'h01, 8'h01}; vt[4].b = {8'hC8, 8'h7F, 8'h5C, 8'hA3};
    vt[4].exp = 8'h48; vt[4].nm = "unit_coef";
    vt[5].a = {8'h80, 8'h40, 8'h20, 8'h10}; vt[5].b = {8'h08, 8'h04, 8'h02, 8'h01};
    vt[5].exp = 8'h27; vt[5].nm = "reduction";

    cyc(8'h55, 8'hAA, 1'b0, "reset");
    chk("reset_state", result, 8'h00);
    cyc(8'h12, 8'h34, 1'b0, "reset");
    chk("reset_hold", result, 8'h00);

    // Table groups run back-to-back with no idle cycles
    for (int i = 0; i < 6; i++) run_vec(vt[i]);
    cyc(8'h01, 8'h01, 1'b1, "fill");
    cyc(8'h01, 8'h01, 1'b1, "fill");
    cyc(8'h01, 8'h01, 1'b1, "fill");
    cyc(8'h01, 8'h01, 1'b1, "fill");

    // Reset held while streaming: result stays zero
    for (int k = 0; k < 8; k++) begin
      cyc(vt[0].a[k % 4], vt[0].b[k % 4], 1'b0, "rst_stream");
      chk("rst_stream_zero", result, 8'h00);
    end

    // Exact latency of the MixColumns row from a clean start
    for (int k = 0; k < 4; k++) begin
      cyc(vt[1].a[k], vt[1].b[k], 1'b1, "lat");
      if (k == 2) chk("lat_before", result, 8'h00);
    end
`ifdef GF8_PRODUCT_PIPE_EN
    chk("lat_edge4_pipe", result, 8'h00);
    cyc(8'h00, 8'h00, 1'b1, "lat");
    chk("lat_edge5_pipe", result, 8'h47);
`else
    chk("lat_edge4", result, 8'h47);
    cyc(8'h00, 8'h00, 1'b1, "lat");
    chk("lat_edge5_hold", result, 8'h47);
`endif
    cyc(8'h00, 8'h00, 1'b1, "lat");
    cyc(8'h00, 8'h00, 1'b1, "lat");
    cyc(8'h00, 8'h00, 1'b1, "lat");

    // Mid-group reset aborts the partial group; release restarts at element 0
    cyc(vt[2].a[0], vt[2].b[0], 1'b1, "abort");
    cyc(vt[2].a[1], vt[2].b[1], 1'b1, "abort");
    cyc(8'hFF, 8'hFF, 1'b0, "abort");
    chk("abort_zero", result, 8'h00);
    run_vec(vt[5]);
    run_vec(vt[0]);
    cyc(8'h00, 8'h00, 1'b1, "fill");
    cyc(8'h00, 8'h00, 1'b1, "fill");
    cyc(8'h00, 8'h00, 1'b1, "fill");
    cyc(8'h00, 8'h00, 1'b1, "fill");

    for (int k = 0; k < 400; k++) begin
      cyc(8'($urandom), 8'($urandom), ($urandom_range(0, 39) != 0), "random");
    end

    if (dq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL pending_checks: %0d scheduled checks never reached, required 0", dq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
